// File: rtl/seq_detect_scheduler.sv
// Shared 3-bit serial pattern detector time-multiplexed over NCH channels by a
// round-robin arbiter; per-channel history, fill and saturating match counters.
module seq_detect_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] din,
  output logic [NCH-1:0] gnt,
  input  logic           cfg_we,
  input  logic [2:0]     cfg_pattern,
  output logic           match_valid,
  output logic [1:0]     match_ch,
  input  logic [1:0]     cnt_sel,
  output logic [CW-1:0]  cnt_rd
);

  logic [2:0]    pattern;
  logic [1:0]    hist [NCH];
  logic [1:0]    fill [NCH];
  logic [CW-1:0] cnt  [NCH];
  logic [1:0]    last_granted;

  logic          found;
  logic [1:0]    gidx;
  logic [1:0]    idx;
  logic          match_hit;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found     = 1'b0;
    gidx      = 2'd0;
    idx       = 2'd0;
    gnt       = '0;
    match_hit = 1'b0;
    if (!reset && !cfg_we) begin
      for (int k = 0; k < NCH; k++) begin
        idx = last_granted + 2'(k + 1);
        if (!found && req[idx]) begin
          found = 1'b1;
          gidx  = idx;
        end
      end
    end
    if (found) begin
      gnt[gidx] = 1'b1;
      match_hit = (fill[gidx] == 2'd2) && ({hist[gidx], din[gidx]} == pattern);
    end
  end

  assign cnt_rd = cnt[cnt_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern      <= 3'b011;
      last_granted <= 2'd3;
      match_valid  <= 1'b0;
      match_ch     <= 2'd0;
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= 2'd0;
        fill[i] <= 2'd0;
        cnt[i]  <= '0;
      end
    end else if (cfg_we) begin
      pattern     <= cfg_pattern;
      match_valid <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= 2'd0;
        fill[i] <= 2'd0;
        cnt[i]  <= '0;
      end
    end else begin
      match_valid <= match_hit;
      if (match_hit) match_ch <= gidx;
      if (found) begin
        last_granted <= gidx;
        hist[gidx]   <= {hist[gidx][0], din[gidx]};
        if (fill[gidx] != 2'd2) fill[gidx] <= fill[gidx] + 2'd1;
        // Counter saturates rather than wrapping.
        if (match_hit && (cnt[gidx] != {CW{1'b1}})) cnt[gidx] <= cnt[gidx] + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler: stimulus pushes expected match
// channels into a queue; a monitor pops and compares on every match_valid.
module tb_seq_detect_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       cfg_we;
  logic [2:0] cfg_pattern;
  logic       match_valid;
  logic [1:0] match_ch;
  logic [1:0] cnt_sel;
  logic [7:0] cnt_rd;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q [$];

  seq_detect_scheduler #(.NCH(4), .CW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .match_valid(match_valid), .match_ch(match_ch),
    .cnt_sel(cnt_sel), .cnt_rd(cnt_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every reported match must correspond to a queued expectation.
  always @(negedge clk) begin
    if (match_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_match: got ch %0d expected none at %0t", match_ch, $time);
      end else begin
        chk("match_ch", 32'(match_ch), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = 4'b1111; din = 4'b0000; cfg_we = 1'b1; cfg_pattern = 3'b111;
    #1 chk("gnt_in_reset", 32'(gnt), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req = 4'b0000; cfg_we = 1'b0; cfg_pattern = 3'b000;
  endtask

  task automatic chk_cnt(input int sel, input int exp, input string name);
    cnt_sel = 2'(sel);
    #1 chk(name, 32'(cnt_rd), 32'(exp));
  endtask

  task automatic send_bit(input int ch, input logic b, input logic exp_m);
    @(negedge clk);
    req = 4'b0000; din = 4'b0000;
    req[ch] = 1'b1; din[ch] = b;
    #1 chk("gnt_single", 32'(gnt), 32'(4'b0001 << ch));
    if (exp_m) exp_q.push_back(2'(ch));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = 4'b0000; din = 4'b0000;
    end
  endtask

  initial begin
    logic [3:0] rr_seq [8];
    logic [3:0] ct_seq [6];
    logic       b1 [3];
    logic       bits33 [7];
    logic       exp33 [7];
    int p1, p2;
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ct_seq = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010, 4'b0100};
    b1     = '{1'b0, 1'b1, 1'b1};
    bits33 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp33  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    reset = 1'b1; req = '0; din = '0; cfg_we = 1'b0; cfg_pattern = '0; cnt_sel = '0;

    // Reset state
    do_reset();
    chk("match_valid_rst", 32'(match_valid), 32'h0);
    chk("match_ch_rst", 32'(match_ch), 32'h0);
    for (int s = 0; s < 4; s++) chk_cnt(s, 0, "cnt_rst");

    // Round-robin with all requests high
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req = 4'b1111; din = 4'b0000;
      #1 chk("gnt_rr", 32'(gnt), 32'(rr_seq[i]));
    end
    idle(2);

    // Channel 0 alone, overlapping detection
    do_reset();
    for (int i = 0; i < 7; i++) send_bit(0, bits33[i], exp33[i]);
    idle(2);
    chk_cnt(0, 2, "cnt0_after_seq");

    // Channels 1 and 2 interleaved under contention
    do_reset();
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    p1 = 0; p2 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req = 4'b0000; din = 4'b0000;
      req[1] = (p1 < 3); req[2] = (p2 < 3);
      din[1] = b1[p1 < 3 ? p1 : 0];
      din[2] = b1[p2 < 3 ? p2 : 0];
      #1 chk("gnt_contend", 32'(gnt), 32'(ct_seq[i]));
      if (gnt[1]) p1++;
      if (gnt[2]) p2++;
      @(posedge clk);
    end
    idle(2);
    chk_cnt(0, 0, "cnt0_xtalk");
    chk_cnt(1, 1, "cnt1_contend");
    chk_cnt(2, 1, "cnt2_contend");
    chk_cnt(3, 0, "cnt3_xtalk");

    // Pattern write with a simultaneous request
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 3'b101; req = 4'b0001; din = 4'b0001;
    #1 chk("gnt_cfg_we", 32'(gnt), 32'h0);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0; req = 4'b0000; din = 4'b0000;
    chk_cnt(1, 0, "cnt1_cleared");
    chk_cnt(2, 0, "cnt2_cleared");
    send_bit(0, 1'b1, 1'b0);
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b1);
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b1);
    idle(2);
    chk_cnt(0, 2, "cnt0_pat101");

    // Reset mid-stream restarts fill
    do_reset();
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1; req = 4'b0001; din = 4'b0001;
    #1 chk("gnt_midreset", 32'(gnt), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req = 4'b0000;
    send_bit(0, 1'b1, 1'b0);
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    send_bit(0, 1'b1, 1'b1);
    idle(2);
    chk_cnt(0, 1, "cnt0_after_reset");

    // Counter saturation on channel 3
    do_reset();
    for (int m = 0; m < 300; m++) begin
      send_bit(3, 1'b0, 1'b0);
      send_bit(3, 1'b1, 1'b0);
      send_bit(3, 1'b1, 1'b1);
    end
    idle(3);
    chk_cnt(3, 255, "cnt3_saturate");

    chk("pending_matches", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
